// File: rtl/Definitions.sv
// DES constant tables, key schedule data and FSM state encoding.
// Table entries use DES numbering: entry value 1 is the MSB of the source word.
package des_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam byte unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam byte unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam byte unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,
         6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27,
        28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam byte unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam byte unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam byte unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28,
        15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56,
        34, 53, 46, 42, 50, 36, 29, 32
    };

    // Encryption left-shift amounts, rounds 1..16
    localparam logic [1:0] SHIFT_T [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Indexed by {b5,b0,b4..b1} of the 6-bit S-box input
    localparam logic [3:0] SBOX_T [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-int'(IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-int'(FP_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-int'(E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-int'(P_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-int'(PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-int'(PC2_T[i])];
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        logic [27:0] y;
        unique case (s)
            2'd1:    y = {x[0], x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic key_par_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) ok = ok & (^k[8*i +: 8]);
        return ok;
    endfunction

endpackage

// File: rtl/des_f_func.sv
// DES round function f(R,K): expansion, subkey mix, eight S-boxes, P permutation.
module des_f_func
    import des_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [47:0] i_k,
    output logic [31:0] o_f
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    assign w_x = e_exp(i_r) ^ i_k;

    always_comb begin
        w_s = '0;
        for (int i = 0; i < 8; i++) begin
            w_s[31-4*i -: 4] = SBOX_T[i][{w_x[47-6*i], w_x[42-6*i],
                                          w_x[46-6*i -: 4]}];
        end
    end

    assign o_f = p_perm(w_s);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core, one round per cycle, valid/ready at both ends.
// Define DES_KEY_PARITY_EN to add the key odd-parity check and key_err output.
module des_decrypt_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_out
`ifdef DES_KEY_PARITY_EN
    ,
    output logic        key_err
`endif
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [63:0] r_plain;
    logic [63:0] w_ip;
    logic [55:0] w_cd0;
    logic [1:0]  w_shift;
    logic [3:0]  w_sidx;
    logic [27:0] w_c;
    logic [27:0] w_d;
    logic [47:0] w_k;
    logic [31:0] w_f;
    logic [31:0] w_r_new;
    logic        w_key_bad;
    logic        w_last;

    assign w_ip   = ip_perm(cipher_in);
    assign w_cd0  = pc1_perm(key_in);
    assign w_last = (r_cnt == 4'd15);

    // Round j undoes the shift of encryption round 18-j; 0-r_cnt == 16-r_cnt here
    assign w_sidx  = 4'd0 - r_cnt;
    assign w_shift = (r_cnt == 4'd0) ? 2'd0 : SHIFT_T[w_sidx];
    assign w_c     = rotr28(r_c, w_shift);
    assign w_d     = rotr28(r_d, w_shift);
    assign w_k     = pc2_perm({w_c, w_d});
    assign w_r_new = r_l ^ w_f;

`ifdef DES_KEY_PARITY_EN
    logic r_key_err;
    assign w_key_bad = ~key_par_ok(key_in);
    assign key_err   = r_key_err;
`else
    assign w_key_bad = 1'b0;
`endif

    des_f_func u_f (
        .i_r (r_r),
        .i_k (w_k),
        .o_f (w_f)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = w_key_bad ? S_DONE : S_ROUND;
            S_ROUND: if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_l     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_plain <= '0;
`ifdef DES_KEY_PARITY_EN
            r_key_err <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_l   <= w_ip[63:32];
                    r_r   <= w_ip[31:0];
                    r_c   <= w_cd0[55:28];
                    r_d   <= w_cd0[27:0];
                    r_cnt <= '0;
                    if (w_key_bad) r_plain <= '0;
`ifdef DES_KEY_PARITY_EN
                    r_key_err <= w_key_bad;
`endif
                end
                S_ROUND: begin
                    r_l   <= r_r;
                    r_r   <= w_r_new;
                    r_c   <= w_c;
                    r_d   <= w_d;
                    r_cnt <= r_cnt + 4'd1;
                    // Final swap: output is FP(R16 || L16)
                    if (w_last) r_plain <= fp_perm({w_r_new, r_r});
                end
                default: ;
            endcase
        end
    end

    assign plain_out = r_plain;

endmodule
